// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-port drain engine with 2-entry valid/ready output buffer
//
// Turns the one-cycle-latency read port of the synchronous FIFO into a
// valid/ready streaming master. A 2-entry buffer absorbs the read latency,
// so the stream runs at one word per cycle and loses nothing under backpressure.
//
// Ports:
//   clk         system clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   en          drain enable; 0 stops new reads, buffered words still drain
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe (combinational)
//   fifo_data   FIFO data_out, valid the cycle after an accepted read
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_data      output word (head of buffer)
//   idle        buffer empty and no read in flight
//   word_cnt    delivered-word count, wraps modulo 2^CNT_WIDTH
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                 occ_q;
    occ_t                 occ_d;
    logic                 inflight_q;
    logic [WIDTH-1:0]     head_q;
    logic [WIDTH-1:0]     tail_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 pop;
    logic                 capture;
    logic [1:0]           occ_bits;
    logic [1:0]           credit;

    assign occ_bits = occ_q;
    assign m_valid  = (occ_q != EMPTY);
    assign m_data   = head_q;
    assign pop      = m_valid & m_ready;
    assign capture  = inflight_q;
    assign idle     = (occ_q == EMPTY) & ~inflight_q;
    assign word_cnt = cnt_q;

    // Slots already spoken for after this cycle: buffered words plus the word
    // arriving now, minus the one leaving. pop implies occ>0, so no underflow.
    assign credit = occ_bits + {1'b0, inflight_q} - {1'b0, pop};

    // rst_n gates the strobe so the FIFO sees no read while reset is held.
    assign fifo_rd_en = rst_n & en & ~fifo_empty & (credit < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            if (pop) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({capture, pop})
            2'b10: begin
                case (occ_q)
                    EMPTY:   occ_d = ONE;
                    ONE:     occ_d = TWO;
                    default: occ_d = occ_q;
                endcase
            end
            2'b01: begin
                case (occ_q)
                    TWO:     occ_d = ONE;
                    ONE:     occ_d = EMPTY;
                    default: occ_d = occ_q;
                endcase
            end
            default: occ_d = occ_q;
        endcase
    end

    // head_q is always the oldest word; tail_q only matters in TWO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (capture && !pop) begin
                if (occ_q == EMPTY) begin
                    head_q <= fifo_data;
                end else begin
                    tail_q <= fifo_data;
                end
            end else if (!capture && pop) begin
                // Leaving ONE keeps the popped word in head_q; harmless, m_valid is 0.
                if (occ_q == TWO) begin
                    head_q <= tail_q;
                end
            end else if (capture && pop) begin
                if (occ_q == TWO) begin
                    head_q <= tail_q;
                    tail_q <= fifo_data;
                end else begin
                    head_q <= fifo_data;
                end
            end
        end
    end

    // The credit check never lets a word arrive into a full, stalled buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !pop && occ_q == TWO));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          idle;
    logic [CW-1:0] word_cnt;

    fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .idle       (idle),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference: fq is the FIFO contents, exp_q every word accepted but not yet delivered.
    logic [W-1:0]  fq[$];
    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] exp_cnt;
    int            checks = 0;
    int            errors = 0;
    int            cyc, n_rd, n_pop, first_rd, first_pop, last_pop;
    logic          prev_stall;
    logic [W-1:0]  prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; n_rd = 0; n_pop = 0; first_rd = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic push(input logic [W-1:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic model_reset();
        fq.delete();
        exp_q.delete();
        exp_cnt    = '0;
        prev_stall = 1'b0;
        fifo_empty = 1'b1;
    endtask

    // One clock cycle: sample/check at negedge, update FIFO model after posedge.
    task automatic tick();
        logic         rd;
        logic [W-1:0] want;
        @(negedge clk);
        cyc++;
        rd = fifo_rd_en;
        if (fifo_empty || !en) check("rd_gated", {31'd0, rd}, 32'd0);
        if (prev_stall) begin
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        if (exp_q.size() == 0) check("no_phantom_valid", {31'd0, m_valid}, 32'd0);
        check("word_cnt", {28'd0, word_cnt}, {28'd0, exp_cnt});
        if (m_valid && m_ready) begin
            want = 'x;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            check("order", {24'd0, m_data}, {24'd0, want});
            exp_cnt = exp_cnt + 1'b1;
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (rd) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; fifo_empty = 1'b0; fifo_data = '0;
        model_reset();
        fifo_empty = 1'b0;
        #12;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_word_cnt", {28'd0, word_cnt}, 32'd0);
        check("rst_rd_en_held", {31'd0, fifo_rd_en}, 32'd0);
        fifo_empty = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Streaming latency and throughput
        clr_stats();
        push(8'h77); push(8'h1B); push(8'h5B); push(8'h19);
        for (int i = 0; i < 8; i++) tick();
        check("t1_first_valid_latency", first_pop - first_rd, 32'd2);
        check("t1_pops", n_pop, 32'd4);
        check("t1_consecutive", last_pop - first_pop, 32'd3);
        check("t1_reads", n_rd, 32'd4);
        check("t1_idle", {31'd0, idle}, 32'd1);

        // Backpressure: buffer fills with two words then reads stop
        clr_stats();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) tick();
        check("t2_reads_stalled", n_rd, 32'd2);
        check("t2_valid", {31'd0, m_valid}, 32'd1);
        check("t2_head", {24'd0, m_data}, 32'hA0);
        clr_stats();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check("t2_pops", n_pop, 32'd8);
        check("t2_consecutive", last_pop - first_pop, 32'd7);

        // Toggling ready
        clr_stats();
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i * 7));
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        check("t3_pops", n_pop, 32'd6);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t3_idle", {31'd0, idle}, 32'd1);

        // Enable off, then disable one cycle after the first read
        clr_stats();
        en = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3);
        for (int i = 0; i < 6; i++) tick();
        check("t4_no_reads", n_rd, 32'd0);
        en = 1'b1;
        for (int i = 0; i < 10 && n_rd == 0; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t4_one_read", n_rd, 32'd1);
        check("t4_inflight_delivered", n_pop, 32'd1);
        check("t4_valid_low", {31'd0, m_valid}, 32'd0);
        check("t4_idle", {31'd0, idle}, 32'd1);
        en = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("t4_drained", exp_q.size(), 32'd0);

        // Asynchronous reset mid-cycle with a full buffer
        m_ready = 1'b0;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        for (int i = 0; i < 6; i++) tick();
        check("t5_full_valid", {31'd0, m_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'd0, m_valid}, 32'd0);
        check("t5_async_cnt", {28'd0, word_cnt}, 32'd0);
        check("t5_async_idle", {31'd0, idle}, 32'd1);
        check("t5_async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;

        // Counter wrap: 17 words into a 4-bit counter
        clr_stats();
        for (int i = 0; i < 17; i++) push(8'(i * 13 + 5));
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check("t6_pops", n_pop, 32'd17);
        check("t6_wrap_cnt", {28'd0, word_cnt}, 32'd1);

        // Randomized traffic against the reference queues
        clr_stats();
        for (int i = 0; i < 500; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fq.size() < 16) push(8'($urandom));
            tick();
        end
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_idle", {31'd0, idle}, 32'd1);
        check("rand_valid_low", {31'd0, m_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side drain engine for the team's synchronous FIFO (rd_en/empty/data_out, one-cycle registered read latency).
- Converts the FIFO read port into a valid/ready streaming master, so downstream consumers never handle FIFO read latency.
- Holds a 2-entry output buffer, giving full one-word-per-cycle throughput under continuous m_ready and no data loss under backpressure.
- Keeps a running count of words delivered.

Parameters:
- WIDTH, 8, data width; must match the FIFO WIDTH.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  drain enable; 0 stops new FIFO reads, but buffered words still drain.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read strobe (combinational).
- fifo_data  input  WIDTH  FIFO data_out; valid the cycle after an accepted read.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  WIDTH  output word (head of buffer).
- idle  output  1  buffer empty and no read in flight.
- word_cnt  output  CNT_WIDTH  words delivered (m_valid & m_ready), wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears buffer occupancy, both buffer entries, inflight and word_cnt.
  - m_valid=0, m_data=0, idle=1, word_cnt=0.
  - fifo_rd_en is held 0 while rst_n=0.
- Internal state:
  - Buffer occupancy state machine: EMPTY(0) / ONE(1) / TWO(2).
  - inflight flag = registered fifo_rd_en, meaning a word arrives on fifo_data this cycle.
- pop = m_valid & m_ready.
- credit = occ + inflight - pop (0..2).
- fifo_rd_en = en & !fifo_empty & (credit < 2).
  - Never asserted when fifo_empty=1.
  - Back-to-back reads are allowed.
- Capture: when inflight=1, fifo_data is written into the buffer tail in that cycle.
- Occupancy transitions:
  - Capture only: EMPTY->ONE, ONE->TWO.
  - Pop only: TWO->ONE, ONE->EMPTY.
  - Capture and pop together: occupancy unchanged. In ONE, the captured word becomes head on the next cycle.
  - Capture in TWO without pop is impossible by construction; flag it as an assertion.
- Output:
  - m_valid = (occ != 0), registered state.
  - m_data = head entry.
  - m_data/m_valid remain stable while m_valid & !m_ready.
  - After a pop with no new capture, m_data holds the popped value until the next capture; it is don't-care when m_valid=0.
- Latency:
  - FIFO non-empty with buffer empty: fifo_rd_en in cycle N, m_valid high in cycle N+2, visible after the N+1 capture edge.
  - Throughput is 1 word/cycle with continuous m_ready.
- en deasserted mid-stream:
  - Reads stop immediately.
  - A word in flight is still captured.
  - The buffer drains normally.
- FIFO becomes empty: fifo_rd_en drops the same cycle; no extra read.
- idle = (occ==0) & !inflight.
- word_cnt increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- Ordering: words are delivered strictly in FIFO order, with none dropped or duplicated.
- Reset mid-operation:
  - All state clears immediately.
  - Any buffered or in-flight word is discarded; the FIFO is reset by the same rst_n.
  - After release, the block behaves as after a cold reset.

Test Plan:
- Reset, then FIFO holds 0x77,0x1B,0x5B,0x19; en=1, m_ready=1 -> m_data 0x77,0x1B,0x5B,0x19 on 4 consecutive cycles starting 2 cycles after first fifo_rd_en; word_cnt=4; idle=1 at end.
- FIFO holds 8 words, m_ready=0 for 10 cycles -> exactly 2 fifo_rd_en pulses, m_valid=1, m_data=first word stable; then m_ready=1 -> all 8 delivered in order, consecutively.
- m_ready toggling 1,0,1,0 with FIFO holding 6 words -> no fifo_rd_en while empty, no loss or duplication, word_cnt=6.
- en=0 with FIFO non-empty -> fifo_rd_en never asserted; en 1->0 one cycle after first read -> in-flight word delivered, then m_valid=0, idle=1.
- Assert rst_n=0 asynchronously (mid-cycle) with occ=2 -> m_valid, word_cnt, idle become 0,0,1 immediately, without waiting for a clock edge.
- CNT_WIDTH=4, deliver 17 words -> word_cnt=1.
